// File: rtl/uart_pkg.sv
// Shared definitions for the UART CSR block: register map, STATUS/IE bit
// positions, RX FIFO entry format and reset values.
package uart_pkg;

    // Register selected by ip_addr[4:2]; offset = index * 4.
    typedef enum logic [2:0] {
        REG_TX_DATA   = 3'd0,
        REG_RX_DATA   = 3'd1,
        REG_BAUD      = 3'd2,
        REG_CTRL      = 3'd3,
        REG_STATUS    = 3'd4,
        REG_IE        = 3'd5,
        REG_RX_THRESH = 3'd6,
        REG_NONE      = 3'd7
    } reg_sel_e;

    localparam logic [4:0] OFF_TX_DATA   = 5'h00;
    localparam logic [4:0] OFF_RX_DATA   = 5'h04;
    localparam logic [4:0] OFF_BAUD      = 5'h08;
    localparam logic [4:0] OFF_CTRL      = 5'h0C;
    localparam logic [4:0] OFF_STATUS    = 5'h10;
    localparam logic [4:0] OFF_IE        = 5'h14;
    localparam logic [4:0] OFF_RX_THRESH = 5'h18;

    localparam int ST_TX_READY     = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_PARITY_ERR   = 3;
    localparam int ST_OVERFLOW     = 4;
    localparam int ST_UNDERRUN     = 5;
    localparam int ST_TX_OVR       = 6;
    localparam int ST_LEVEL_LSB    = 8;

    localparam int IRQ_SRC_W  = 7;
    localparam int RX_ENTRY_W = 10;

    // Sticky flags in STATUS[6:3] order (MSB = tx_ovr).
    typedef struct packed {
        logic tx_ovr;
        logic underrun;
        logic overflow;
        logic parity_err;
    } sticky_t;

    localparam logic [3:0]           CTRL_RESET   = 4'h0;
    localparam logic [IRQ_SRC_W-1:0] IE_RESET     = '0;
    localparam logic [7:0]           THRESH_RESET = 8'h00;
    localparam sticky_t              STICKY_RESET = '0;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive character FIFO: DEPTH entries of {parity_err, data[8:0]}, with
// extra-bit pointers so level spans 0..DEPTH without ambiguity.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  push,
    input  logic [RX_ENTRY_W-1:0] push_data,
    input  logic                  pop,
    output logic [RX_ENTRY_W-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [LVL_W-1:0]      level
);

    logic [RX_ENTRY_W-1:0] mem [DEPTH];
    logic [LVL_W-1:0]      wr_ptr;
    logic [LVL_W-1:0]      rd_ptr;
    logic                  push_en;
    logic                  pop_en;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign pop_en  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign push_en = push && (!full || pop_en);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + LVL_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + LVL_W'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_csr_fifo.sv
// UART control/status register block: CSR decode, TX push, RX FIFO with
// sticky error flags and a registered level interrupt.
module uart_csr_fifo
    import uart_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int BAUD_W   = 16,
    parameter int DATA_W   = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [4:0]        ip_addr,
    input  logic [DATA_W-1:0] ip_write_data,
    input  logic [3:0]        ip_byte_strobe,
    input  logic              valid_reg_write,
    input  logic              valid_reg_read,
    output logic [DATA_W-1:0] ip_read_data,
    output logic              ip_read_data_valid,
    output logic              tx_data_reg_wr,
    output logic [8:0]        tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [8:0]        rx_data,
    input  logic              rx_parity_err,
    output logic [BAUD_W-1:0] baud_val,
    output logic              data_bits,
    output logic              parity_en,
    output logic              parity_odd0_even1,
    output logic              rx_enable,
    output logic              irq
);

    localparam int LVL_W = $clog2(RX_DEPTH) + 1;

    reg_sel_e              sel;
    logic [BAUD_W-1:0]     baud_q;
    logic [3:0]            ctrl_q;
    logic [IRQ_SRC_W-1:0]  ie_q;
    logic [7:0]            thresh_q;
    sticky_t               sticky_q;
    logic [3:0]            sticky_set;
    logic [3:0]            sticky_clr;

    logic                  wr_tx;
    logic                  rd_rx;
    logic                  push_req;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RX_ENTRY_W-1:0] fifo_rd_data;
    logic [LVL_W-1:0]      fifo_level;
    logic [8:0]            level9;
    logic                  thresh_hit;
    logic [IRQ_SRC_W-1:0]  irq_src;
    logic [DATA_W-1:0]     status_word;
    logic [DATA_W-1:0]     rd_mux;
    logic                  unused_inputs;

    assign sel   = reg_sel_e'(ip_addr[4:2]);
    assign wr_tx = valid_reg_write && (sel == REG_TX_DATA) && ip_byte_strobe[0];
    assign rd_rx = valid_reg_read && (sel == REG_RX_DATA);

    // TX push is a valid/ready transfer: tx_data_reg_wr is only raised when
    // tx_ready is already high, so every pulse is a completed transfer; a
    // write while tx_ready is low is dropped and recorded as tx_ovr.
    assign tx_data_reg_wr = wr_tx && tx_ready && !ARESET;
    assign tx_data        = ip_write_data[8:0];

    assign push_req = rx_valid && rx_enable;
    assign fifo_pop = rd_rx && !fifo_empty;

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .push      (push_req),
        .push_data ({rx_parity_err, rx_data}),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign sticky_set = {
        wr_tx && !tx_ready,
        rd_rx && fifo_empty,
        push_req && fifo_full && !fifo_pop,
        push_req && (!fifo_full || fifo_pop) && rx_parity_err
    };
    assign sticky_clr = (valid_reg_write && (sel == REG_STATUS) && ip_byte_strobe[0])
                        ? ip_write_data[6:3] : 4'h0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            baud_q   <= '0;
            ctrl_q   <= CTRL_RESET;
            ie_q     <= IE_RESET;
            thresh_q <= THRESH_RESET;
            sticky_q <= STICKY_RESET;
        end else begin
            if (valid_reg_write) begin
                case (sel)
                    REG_BAUD: begin
                        if (ip_byte_strobe[0]) baud_q[7:0]        <= ip_write_data[7:0];
                        if (ip_byte_strobe[1]) baud_q[BAUD_W-1:8] <= ip_write_data[BAUD_W-1:8];
                    end
                    REG_CTRL:      if (ip_byte_strobe[0]) ctrl_q   <= ip_write_data[3:0];
                    REG_IE:        if (ip_byte_strobe[0]) ie_q     <= ip_write_data[IRQ_SRC_W-1:0];
                    REG_RX_THRESH: if (ip_byte_strobe[0]) thresh_q <= ip_write_data[7:0];
                    default: ;
                endcase
            end
            // Set wins over a same-cycle clear.
            sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
        end
    end

    assign baud_val          = baud_q;
    assign data_bits         = ctrl_q[0];
    assign parity_en         = ctrl_q[1];
    assign parity_odd0_even1 = ctrl_q[2];
    assign rx_enable         = ctrl_q[3];

    // Level is reported in an 8-bit field; thresholds compare at full width.
    assign level9     = 9'(fifo_level);
    assign thresh_hit = (thresh_q != 8'h00) && (level9 >= {1'b0, thresh_q});
    assign irq_src    = {sticky_q, fifo_full, thresh_hit, tx_ready};

    always_comb begin
        status_word                  = '0;
        status_word[ST_TX_READY]     = tx_ready;
        status_word[ST_RX_NOT_EMPTY] = !fifo_empty;
        status_word[ST_RX_FULL]      = fifo_full;
        status_word[ST_TX_OVR:ST_PARITY_ERR] = sticky_q;
        status_word[ST_LEVEL_LSB +: 8]       = level9[7:0];
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_RX_DATA:   rd_mux = fifo_empty ? '0 : DATA_W'(fifo_rd_data);
            REG_BAUD:      rd_mux = DATA_W'(baud_q);
            REG_CTRL:      rd_mux = DATA_W'(ctrl_q);
            REG_STATUS:    rd_mux = status_word;
            REG_IE:        rd_mux = DATA_W'(ie_q);
            REG_RX_THRESH: rd_mux = DATA_W'(thresh_q);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ip_read_data       <= '0;
            ip_read_data_valid <= 1'b0;
            irq                <= 1'b0;
        end else begin
            ip_read_data       <= valid_reg_read ? rd_mux : '0;
            ip_read_data_valid <= valid_reg_read;
            irq                <= |(irq_src & ie_q);
        end
    end

    assign unused_inputs = ^{ip_addr[1:0], ip_byte_strobe[3:2], ip_write_data[DATA_W-1:BAUD_W]};

endmodule

// File: tb/tb_uart_csr_fifo.sv
// Directed and randomized checks of uart_csr_fifo against a queue-based
// model of the RX FIFO, sticky flags and register file.
module tb_uart_csr_fifo;

    localparam int RX_DEPTH = 8;
    localparam int BAUD_W   = 16;
    localparam int DATA_W   = 32;

    localparam logic [4:0] A_TX     = 5'h00;
    localparam logic [4:0] A_RX     = 5'h04;
    localparam logic [4:0] A_BAUD   = 5'h08;
    localparam logic [4:0] A_CTRL   = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;
    localparam logic [4:0] A_IE     = 5'h14;
    localparam logic [4:0] A_THRESH = 5'h18;
    localparam logic [4:0] A_HOLE   = 5'h1C;

    logic              ACLK;
    logic              ARESET;
    logic [4:0]        ip_addr;
    logic [DATA_W-1:0] ip_write_data;
    logic [3:0]        ip_byte_strobe;
    logic              valid_reg_write;
    logic              valid_reg_read;
    logic [DATA_W-1:0] ip_read_data;
    logic              ip_read_data_valid;
    logic              tx_data_reg_wr;
    logic [8:0]        tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [8:0]        rx_data;
    logic              rx_parity_err;
    logic [BAUD_W-1:0] baud_val;
    logic              data_bits;
    logic              parity_en;
    logic              parity_odd0_even1;
    logic              rx_enable;
    logic              irq;

    uart_csr_fifo #(.RX_DEPTH(RX_DEPTH), .BAUD_W(BAUD_W), .DATA_W(DATA_W)) dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .ip_addr           (ip_addr),
        .ip_write_data     (ip_write_data),
        .ip_byte_strobe    (ip_byte_strobe),
        .valid_reg_write   (valid_reg_write),
        .valid_reg_read    (valid_reg_read),
        .ip_read_data      (ip_read_data),
        .ip_read_data_valid(ip_read_data_valid),
        .tx_data_reg_wr    (tx_data_reg_wr),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_parity_err     (rx_parity_err),
        .baud_val          (baud_val),
        .data_bits         (data_bits),
        .parity_en         (parity_en),
        .parity_odd0_even1 (parity_odd0_even1),
        .rx_enable         (rx_enable),
        .irq               (irq)
    );

    // Clock / reset
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard and model
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] model_q[$];
    logic       m_par, m_ovf, m_und, m_txo, m_rx_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status(input logic txr);
        int n;
        n = model_q.size();
        return {16'h0, 8'(n), 1'b0, m_txo, m_und, m_ovf, m_par,
                n == RX_DEPTH, n != 0, txr};
    endfunction

    task automatic model_reset();
        model_q.delete();
        m_par = 0; m_ovf = 0; m_und = 0; m_txo = 0; m_rx_en = 0;
    endtask

    task automatic model_pop(output logic [31:0] d);
        if (model_q.size() == 0) begin
            m_und = 1'b1;
            d = 32'h0;
        end else begin
            d = 32'(model_q.pop_front());
        end
    endtask

    task automatic model_push(input logic [9:0] e);
        if (!m_rx_en) return;
        if (model_q.size() < RX_DEPTH) begin
            model_q.push_back(e);
            if (e[9]) m_par = 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_clear(input logic [3:0] m);
        if (m[0]) m_par = 1'b0;
        if (m[1]) m_ovf = 1'b0;
        if (m[2]) m_und = 1'b0;
        if (m[3]) m_txo = 1'b0;
    endtask

    // Drivers: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        ip_addr = a; ip_write_data = d; ip_byte_strobe = s; valid_reg_write = 1'b1;
        tick();
        valid_reg_write = 1'b0; ip_byte_strobe = 4'h0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        ip_addr = a; valid_reg_read = 1'b1;
        tick();
        valid_reg_read = 1'b0;
        check("rd_valid", 32'(ip_read_data_valid), 32'h1);
        d = ip_read_data;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic push(input logic [8:0] d, input logic p);
        rx_valid = 1'b1; rx_data = d; rx_parity_err = p;
        tick();
        rx_valid = 1'b0; rx_parity_err = 1'b0;
        model_push({p, d});
    endtask

    task automatic read_rx_model(input string tag);
        logic [31:0] exp;
        model_pop(exp);
        read_check(tag, A_RX, exp);
    endtask

    initial begin
        logic [31:0] exp;
        logic [31:0] d;
        logic [8:0]  r;
        int          op;
        logic        do_push, do_rd_rx, do_rd_st, do_clr, prev_full;
        logic [3:0]  clr_m;

        ARESET = 1'b1; ip_addr = '0; ip_write_data = '0; ip_byte_strobe = '0;
        valid_reg_write = 0; valid_reg_read = 0; tx_ready = 1'b1;
        rx_valid = 0; rx_data = '0; rx_parity_err = 0;
        model_reset();
        repeat (3) tick();
        ARESET = 1'b0;

        // Reset state
        check("rst_irq", 32'(irq), 0);
        check("rst_rd_valid", 32'(ip_read_data_valid), 0);
        check("rst_rd_data", ip_read_data, 0);
        check("rst_baud", 32'(baud_val), 0);
        check("rst_ctrl", {28'h0, rx_enable, parity_odd0_even1, parity_en, data_bits}, 0);
        check("rst_tx_wr", 32'(tx_data_reg_wr), 0);
        read_check("rst_status", A_STATUS, model_status(1'b1));
        tick();
        check("idle_rd_data", ip_read_data, 0);
        check("idle_rd_valid", 32'(ip_read_data_valid), 0);

        // BAUD / CTRL programming and readback
        bus_write(A_BAUD, 32'h0000_0145, 4'hF);
        bus_write(A_CTRL, 32'h0000_000B, 4'hF);
        m_rx_en = 1'b1;
        check("baud_val", 32'(baud_val), 32'h145);
        check("ctrl_outs", {28'h0, rx_enable, parity_odd0_even1, parity_en, data_bits}, 32'hB);
        read_check("baud_rb", A_BAUD, 32'h145);
        read_check("ctrl_rb", A_CTRL, 32'hB);
        bus_write(A_BAUD, 32'hFFFF_FFFF, 4'h2);
        read_check("baud_strobe_hi", A_BAUD, 32'hFF45);
        bus_write(A_BAUD, 32'h0000_0001, 4'h1);
        read_check("baud_strobe_lo", A_BAUD, 32'hFF01);
        bus_write(A_BAUD, 32'h0000_0145, 4'h3);
        bus_write(A_HOLE, 32'hFFFF_FFFF, 4'hF);
        read_check("hole_rd", A_HOLE, 0);
        read_check("tx_rd", A_TX, 0);
        bus_write(A_THRESH, 32'hFFFF_FF5A, 4'hF);
        read_check("thresh_rb", A_THRESH, 32'h5A);
        bus_write(A_IE, 32'hFFFF_FFFF, 4'hE);
        read_check("ie_nostrobe", A_IE, 0);
        bus_write(A_THRESH, 32'h0, 4'h1);

        // TX push
        ip_addr = A_TX; ip_write_data = 32'h0000_0155; ip_byte_strobe = 4'h1; valid_reg_write = 1'b1;
        #1;
        check("tx_pulse", 32'(tx_data_reg_wr), 1);
        check("tx_data", 32'(tx_data), 32'h155);
        tick();
        valid_reg_write = 1'b0;
        #1;
        check("tx_pulse_end", 32'(tx_data_reg_wr), 0);
        tx_ready = 1'b0;
        valid_reg_write = 1'b1;
        #1;
        check("tx_blocked", 32'(tx_data_reg_wr), 0);
        tick();
        valid_reg_write = 1'b0; ip_byte_strobe = 4'h0;
        m_txo = 1'b1;
        read_check("tx_ovr_set", A_STATUS, model_status(1'b0));
        tx_ready = 1'b1;
        bus_write(A_STATUS, 32'h40, 4'h1);
        model_clear(4'b1000);
        read_check("tx_ovr_clr", A_STATUS, model_status(1'b1));

        // Overfill then overdrain
        for (int i = 0; i < 9; i++) push(9'($urandom_range(0, 511)), 1'b0);
        bus_read(A_STATUS, d);
        check("full_flag", 32'(d[2]), 1);
        check("ovf_flag", 32'(d[4]), 1);
        check("full_level", 32'(d[15:8]), RX_DEPTH);
        check("full_status", d, model_status(1'b1));
        for (int i = 0; i < 9; i++) read_rx_model("drain");
        read_check("underrun", A_STATUS, model_status(1'b1));
        bus_write(A_STATUS, 32'h78, 4'h1);
        model_clear(4'hF);
        read_check("w1c_all", A_STATUS, model_status(1'b1));

        // Same-cycle overflow set and clear: set wins
        for (int i = 0; i < RX_DEPTH; i++) push(9'($urandom_range(0, 511)), 1'b0);
        ip_addr = A_STATUS; ip_write_data = 32'h10; ip_byte_strobe = 4'h1; valid_reg_write = 1'b1;
        rx_valid = 1'b1; rx_data = 9'h1FF;
        tick();
        valid_reg_write = 1'b0; rx_valid = 1'b0; ip_byte_strobe = 4'h0;
        model_clear(4'b0010);
        model_push(10'h1FF);
        read_check("set_beats_clr", A_STATUS, model_status(1'b1));
        bus_write(A_STATUS, 32'h10, 4'h1);
        model_clear(4'b0010);

        // Full FIFO, simultaneous push and pop
        r = 9'($urandom_range(0, 511));
        rx_valid = 1'b1; rx_data = r; ip_addr = A_RX; valid_reg_read = 1'b1;
        tick();
        rx_valid = 1'b0; valid_reg_read = 0;
        model_pop(exp);
        model_push({1'b0, r});
        check("pushpop_data", ip_read_data, exp);
        read_check("pushpop_status", A_STATUS, model_status(1'b1));
        for (int i = 0; i < RX_DEPTH; i++) read_rx_model("drain2");

        // Empty FIFO, simultaneous push and pop: underrun, push kept
        rx_valid = 1'b1; rx_data = 9'h0A5; ip_addr = A_RX; valid_reg_read = 1'b1;
        tick();
        rx_valid = 1'b0; valid_reg_read = 0;
        model_pop(exp);
        model_push(10'h0A5);
        check("empty_pushpop_data", ip_read_data, exp);
        read_check("empty_pushpop_st", A_STATUS, model_status(1'b1));
        read_rx_model("empty_pushpop_rd");
        bus_write(A_STATUS, 32'h78, 4'h1);
        model_clear(4'hF);

        // rx_enable=0 ignores received characters
        bus_write(A_CTRL, 32'h3, 4'h1);
        m_rx_en = 1'b0;
        push(9'h123, 1'b1);
        read_check("rx_disabled", A_STATUS, model_status(1'b1));
        bus_write(A_CTRL, 32'hB, 4'h1);
        m_rx_en = 1'b1;

        // Threshold interrupt
        bus_write(A_THRESH, 32'h3, 4'h1);
        bus_write(A_IE, 32'h2, 4'h1);
        push(9'h011, 1'b0);
        push(9'h022, 1'b0);
        check("irq_below", 32'(irq), 0);
        push(9'h033, 1'b0);
        check("irq_lag", 32'(irq), 0);
        tick();
        check("irq_thresh", 32'(irq), 1);
        read_rx_model("thresh_rd");
        check("irq_hold", 32'(irq), 1);
        tick();
        check("irq_drop", 32'(irq), 0);
        read_rx_model("thresh_rd2");
        read_rx_model("thresh_rd3");
        bus_write(A_IE, 32'h0, 4'h1);
        bus_write(A_THRESH, 32'h0, 4'h1);

        // Parity error capture
        push(9'h0AA, 1'b1);
        read_check("parity_status", A_STATUS, model_status(1'b1));
        bus_read(A_RX, d);
        void'(model_q.pop_front());
        check("parity_bit9", 32'(d[9]), 1);
        check("parity_data", d, 32'h2AA);
        bus_write(A_STATUS, 32'h08, 4'h1);
        model_clear(4'b0001);

        // Randomized traffic with rx_full interrupt enabled
        bus_write(A_IE, 32'h4, 4'h1);
        for (int it = 0; it < 400; it++) begin
            op       = $urandom_range(0, 9);
            do_push  = ($urandom_range(0, 99) < 55);
            do_rd_rx = (op < 4);
            do_rd_st = (op >= 4 && op < 7);
            do_clr   = (op == 7);
            clr_m    = 4'($urandom_range(0, 15));
            r        = 9'($urandom_range(0, 511));
            rx_valid = do_push; rx_data = r; rx_parity_err = ($urandom_range(0, 7) == 0);
            if (do_rd_rx) begin ip_addr = A_RX; valid_reg_read = 1'b1; end
            if (do_rd_st) begin ip_addr = A_STATUS; valid_reg_read = 1'b1; end
            if (do_clr) begin
                ip_addr = A_STATUS; ip_write_data = {25'h0, clr_m, 3'h0};
                ip_byte_strobe = 4'h1; valid_reg_write = 1'b1;
            end
            prev_full = (model_q.size() == RX_DEPTH);
            exp = 32'h0;
            if (do_rd_st) exp = model_status(1'b1);
            if (do_rd_rx) model_pop(exp);
            if (do_clr)   model_clear(clr_m);
            if (do_push)  model_push({rx_parity_err, r});
            tick();
            rx_valid = 1'b0; rx_parity_err = 1'b0; valid_reg_read = 1'b0;
            valid_reg_write = 1'b0; ip_byte_strobe = 4'h0;
            if (do_rd_rx || do_rd_st) check(do_rd_rx ? "rand_rx" : "rand_status", ip_read_data, exp);
            check("rand_irq_full", 32'(irq), 32'(prev_full));
        end
        read_check("rand_final_status", A_STATUS, model_status(1'b1));

        // Reset mid-stream discards FIFO and pending read response
        while (model_q.size() < 3) push(9'($urandom_range(0, 511)), 1'b0);
        ARESET = 1'b1; ip_addr = A_RX; valid_reg_read = 1'b1; rx_valid = 1'b1; rx_data = 9'h155;
        tick();
        ARESET = 1'b0; valid_reg_read = 1'b0; rx_valid = 1'b0;
        model_reset();
        check("mid_rst_valid", 32'(ip_read_data_valid), 0);
        check("mid_rst_data", ip_read_data, 0);
        check("mid_rst_irq", 32'(irq), 0);
        check("mid_rst_baud", 32'(baud_val), 0);
        check("mid_rst_rx_en", 32'(rx_enable), 0);
        read_check("mid_rst_status", A_STATUS, model_status(1'b1));
        read_check("mid_rst_rx", A_RX, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
